rts_bist_sequencer: RTL and testbench

Session sequencer for the RTS (random test socket) BIST architecture around the CPU under test. On a start request it initialises PRPG, SRSG, SISA and MISR, alternates scan-shift and capture phases for a programmed number of test cycles, unloads the final scan contents, and compares the combined {MISR, SISA} signature against a golden value. It is the only driver of the generator/compactor enables and of the CPU's NbarT test-mode input. It replaces the bench-driven masterRst/done loop with a start/done handshake and an on-chip pass flag.

---
 rtl/rts_pkg.sv | 21 ++
 rtl/rts_bist_sequencer_if.sv | 35 +++
 rtl/rts_cycle_counter.sv | 28 ++
 rtl/rts_bist_sequencer.sv | 126 ++++++++++++
 tb/tb_rts_bist_sequencer.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/rts_pkg.sv
// Shared definitions for the RTS BIST session sequencer: state encoding,
// default session parameters and the compactor widths behind the signature.
package rts_pkg;

   localparam int MISR_W           = 56;
   localparam int SISA_W           = 16;
   localparam int DEF_SIG_W        = MISR_W + SISA_W;
   localparam int DEF_SHIFT_CNT    = 1;
   localparam int DEF_NUM_TST_CYCL = 100;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_INIT    = 3'd1,
      ST_SHIFT   = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_UNLOAD  = 3'd4,
      ST_COMPARE = 3'd5,
      ST_DONE    = 3'd6
   } rts_state_e;

endpackage

// File: rtl/rts_bist_sequencer_if.sv
// Session and test-control bundle between the BIST sequencer (slave side)
// and the environment that requests sessions and observes the result (master side).
interface rts_bist_sequencer_if #(
   parameter int SIG_W = rts_pkg::DEF_SIG_W
);
   // start/done handshake: start is only looked at while the sequencer is idle
   // or done; once accepted, busy covers the whole session and done then holds,
   // with pass valid, until the next accepted start. There is no abort.
   logic             start;
   logic [SIG_W-1:0] sig;
   logic [SIG_W-1:0] golden_sig;
   logic             internalRst;
   logic             NbarT;
   logic             PRPG_En;
   logic             SRSG_En;
   logic             SISA_En;
   logic             MISR_En;
   logic             busy;
   logic             done;
   logic             pass;
   logic [2:0]       state_dbg;

   modport master (
      output start, sig, golden_sig,
      input  internalRst, NbarT, PRPG_En, SRSG_En, SISA_En, MISR_En,
      input  busy, done, pass, state_dbg
   );

   modport slave (
      input  start, sig, golden_sig,
      output internalRst, NbarT, PRPG_En, SRSG_En, SISA_En, MISR_En,
      output busy, done, pass, state_dbg
   );

endinterface

// File: rtl/rts_cycle_counter.sv
// Loadable down-counter; tc flags that the loaded span has been used up and
// the counter then holds at zero instead of wrapping.
module rts_cycle_counter #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         tc
);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && !tc) begin
         count <= count - 1'b1;
      end
   end

   assign tc = (count == '0);

endmodule

// File: rtl/rts_bist_sequencer.sv
// RTS BIST session sequencer: init, SHIFT/CAPTURE test cycles, final unload,
// then a registered signature compare reported through a start/done handshake.
module rts_bist_sequencer
   import rts_pkg::*;
#(
   parameter int SHIFT_CNT    = DEF_SHIFT_CNT,
   parameter int NUM_TST_CYCL = DEF_NUM_TST_CYCL,
   parameter int SIG_W        = DEF_SIG_W
) (
   input logic                 clk,
   input logic                 masterRst_n,
   rts_bist_sequencer_if.slave bus
);

   localparam int SH_W = $clog2(SHIFT_CNT + 1);
   localparam int TC_W = $clog2(NUM_TST_CYCL + 1);

   // Counters are loaded with span-1 so tc marks the last cycle of the span.
   localparam logic [SH_W-1:0] SH_LOAD = SH_W'(SHIFT_CNT - 1);
   localparam logic [TC_W-1:0] TC_LOAD = TC_W'(NUM_TST_CYCL - 1);

   rts_state_e state;
   rts_state_e next_state;

   logic sh_load, sh_dec, sh_tc;
   logic tc_load, tc_dec, tc_tc;
   logic sig_match;

   rts_cycle_counter #(.W(SH_W)) u_shift_cnt (
      .clk      (clk),
      .rst_n    (masterRst_n),
      .load     (sh_load),
      .load_val (SH_LOAD),
      .dec      (sh_dec),
      .tc       (sh_tc)
   );

   rts_cycle_counter #(.W(TC_W)) u_test_cnt (
      .clk      (clk),
      .rst_n    (masterRst_n),
      .load     (tc_load),
      .load_val (TC_LOAD),
      .dec      (tc_dec),
      .tc       (tc_tc)
   );

   always_ff @(posedge clk or negedge masterRst_n) begin
      if (!masterRst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:    if (bus.start) next_state = ST_INIT;
         ST_INIT:    next_state = ST_SHIFT;
         ST_SHIFT:   if (sh_tc) next_state = ST_CAPTURE;
         ST_CAPTURE: next_state = tc_tc ? ST_UNLOAD : ST_SHIFT;
         ST_UNLOAD:  if (sh_tc) next_state = ST_COMPARE;
         ST_COMPARE: next_state = ST_DONE;
         ST_DONE:    if (bus.start) next_state = ST_INIT;
         default:    next_state = ST_IDLE;
      endcase
   end

   // Moore decode of the state register; the shift counter reloads on every
   // capture so the following SHIFT or UNLOAD phase gets a full span.
   always_comb begin
      bus.internalRst = 1'b0;
      bus.NbarT       = 1'b0;
      bus.PRPG_En     = 1'b0;
      bus.SRSG_En     = 1'b0;
      bus.SISA_En     = 1'b0;
      bus.MISR_En     = 1'b0;
      bus.busy        = 1'b0;
      bus.done        = 1'b0;
      sh_load         = 1'b0;
      sh_dec          = 1'b0;
      tc_load         = 1'b0;
      tc_dec          = 1'b0;
      case (state)
         ST_INIT: begin
            bus.internalRst = 1'b1;
            bus.busy        = 1'b1;
            sh_load         = 1'b1;
            tc_load         = 1'b1;
         end
         ST_SHIFT, ST_UNLOAD: begin
            bus.NbarT   = 1'b1;
            bus.SRSG_En = 1'b1;
            bus.SISA_En = 1'b1;
            bus.busy    = 1'b1;
            sh_dec      = 1'b1;
         end
         ST_CAPTURE: begin
            bus.PRPG_En = 1'b1;
            bus.MISR_En = 1'b1;
            bus.busy    = 1'b1;
            sh_load     = 1'b1;
            tc_dec      = 1'b1;
         end
         ST_COMPARE: bus.busy = 1'b1;
         ST_DONE:    bus.done = 1'b1;
         default: ;
      endcase
   end

   assign sig_match     = (bus.sig[SIG_W-1:0] == bus.golden_sig[SIG_W-1:0]);
   assign bus.state_dbg = state;

   // pass is captured with the transition into DONE and cleared as soon as
   // the sequencer leaves DONE for a new session.
   always_ff @(posedge clk or negedge masterRst_n) begin
      if (!masterRst_n) begin
         bus.pass <= 1'b0;
      end else if (state == ST_COMPARE) begin
         bus.pass <= sig_match;
      end else if (state != ST_DONE || bus.start) begin
         bus.pass <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rts_bist_sequencer.sv
// Bench for rts_bist_sequencer: a default-parameter instance and a
// SHIFT_CNT=3 / NUM_TST_CYCL=4 instance checked against a cycle-index model.
module tb_rts_bist_sequencer;
   import rts_pkg::*;

   logic clk = 1'b0;
   logic masterRst_n;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   rts_bist_sequencer_if #(.SIG_W(72)) bus_a ();
   rts_bist_sequencer_if #(.SIG_W(72)) bus_b ();

   rts_bist_sequencer #(.SHIFT_CNT(1), .NUM_TST_CYCL(100), .SIG_W(72)) u_dut_a (
      .clk         (clk),
      .masterRst_n (masterRst_n),
      .bus         (bus_a.slave)
   );

   rts_bist_sequencer #(.SHIFT_CNT(3), .NUM_TST_CYCL(4), .SIG_W(72)) u_dut_b (
      .clk         (clk),
      .masterRst_n (masterRst_n),
      .bus         (bus_b.slave)
   );

   // {internalRst, NbarT, PRPG_En, SRSG_En, SISA_En, MISR_En, busy, done, pass}
   logic [8:0] obs_a, obs_b;
   assign obs_a = {bus_a.internalRst, bus_a.NbarT, bus_a.PRPG_En, bus_a.SRSG_En,
                   bus_a.SISA_En, bus_a.MISR_En, bus_a.busy, bus_a.done, bus_a.pass};
   assign obs_b = {bus_b.internalRst, bus_b.NbarT, bus_b.PRPG_En, bus_b.SRSG_En,
                   bus_b.SISA_En, bus_b.MISR_En, bus_b.busy, bus_b.done, bus_b.pass};

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected outputs in the cycle after edge e, counted from the edge that takes start.
   function automatic logic [8:0] exp_vec(input int e, input int s, input int n, input bit match);
      int   body, k;
      logic rst, nb, cap, bsy, dn, ps;
      body = n * (s + 1);
      k    = e - 1;
      rst = 1'b0; nb = 1'b0; cap = 1'b0; bsy = 1'b0; dn = 1'b0; ps = 1'b0;
      if (e == 0) begin
         rst = 1'b1; bsy = 1'b1;
      end else if (k < body) begin
         bsy = 1'b1;
         if ((k % (s + 1)) < s) nb = 1'b1;
         else cap = 1'b1;
      end else if (k < body + s) begin
         bsy = 1'b1; nb = 1'b1;
      end else if (k == body + s) begin
         bsy = 1'b1;
      end else begin
         dn = 1'b1; ps = match;
      end
      return {rst, nb, cap, nb, nb, cap, bsy, dn, ps};
   endfunction

   function automatic logic [71:0] rand72();
      logic [95:0] t;
      t = {$urandom, $urandom, $urandom};
      return t[71:0];
   endfunction

   task automatic set_start(input bit sel, input logic v);
      if (sel) bus_b.start = v;
      else bus_a.start = v;
   endtask

   task automatic set_sigs(input bit sel, input logic [71:0] sg, input logic [71:0] gd);
      if (sel) begin
         bus_b.sig = sg; bus_b.golden_sig = gd;
      end else begin
         bus_a.sig = sg; bus_a.golden_sig = gd;
      end
   endtask

   // Call between edges with the DUT in IDLE or DONE; returns #1 after the first done edge.
   task automatic run_session(input string tag, input bit sel, input int s, input int n,
                              input logic [71:0] sg, input logic [71:0] gd,
                              input bit noise, input bit hold);
      logic [8:0] o;
      int done_e, first_done;
      int c_rst, c_nb, c_prpg, c_misr, c_overlap;
      done_e = 2 + n * (s + 1) + s;
      first_done = -1;
      c_rst = 0; c_nb = 0; c_prpg = 0; c_misr = 0; c_overlap = 0;
      set_sigs(sel, sg, gd);
      set_start(sel, 1'b1);
      for (int e = 0; e <= done_e; e++) begin
         @(posedge clk); #1;
         o = sel ? obs_b : obs_a;
         chk($sformatf("%s cycle %0d", tag, e), 72'(o), 72'(exp_vec(e, s, n, sg == gd)));
         c_rst  += int'(o[8]);
         c_nb   += int'(o[7]);
         c_prpg += int'(o[6]);
         c_misr += int'(o[3]);
         c_overlap += int'(o[7] & (o[6] | o[3]));
         if (o[1] && first_done < 0) first_done = e;
         if (noise && e >= 1 && e <= done_e - 3) set_start(sel, 1'($urandom_range(0, 1)));
         else set_start(sel, 1'b0);
      end
      chk({tag, " done edge"}, 72'(first_done), 72'(done_e));
      chk({tag, " internalRst cycles"}, 72'(c_rst), 72'd1);
      chk({tag, " NbarT cycles"}, 72'(c_nb), 72'(n * s + s));
      chk({tag, " PRPG_En cycles"}, 72'(c_prpg), 72'(n));
      chk({tag, " MISR_En cycles"}, 72'(c_misr), 72'(n));
      chk({tag, " capture during shift"}, 72'(c_overlap), 72'd0);
      if (hold) set_start(sel, 1'b1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [71:0] sg, gd;

      // Reset then idle
      masterRst_n = 1'b0;
      set_start(1'b0, 1'b0); set_start(1'b1, 1'b0);
      set_sigs(1'b0, '0, '0); set_sigs(1'b1, '0, '0);
      repeat (3) @(posedge clk);
      #1;
      chk("reset outputs a", 72'(obs_a), 72'd0);
      chk("reset outputs b", 72'(obs_b), 72'd0);
      masterRst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         chk($sformatf("idle a cycle %0d", i), 72'(obs_a), 72'd0);
         chk($sformatf("idle b cycle %0d", i), 72'(obs_b), 72'd0);
      end
      chk("idle state a", 72'(bus_a.state_dbg), 72'(ST_IDLE));

      // Default sessions: matching and single-bit mismatch
      run_session("dflt pass", 1'b0, 1, 100, 72'h5A, 72'h5A, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("done held a", 72'({bus_a.done, bus_a.pass}), 72'b11);
      run_session("dflt bit0", 1'b0, 1, 100, 72'h5A, 72'h5B, 1'b0, 1'b0);

      // Parameter sweep with ignored start pulses mid-session
      sg = rand72();
      run_session("sweep pass", 1'b1, 3, 4, sg, sg, 1'b1, 1'b0);
      sg = rand72();
      gd = sg ^ (72'd1 << $urandom_range(0, 71));
      run_session("sweep miss", 1'b1, 3, 4, sg, gd, 1'b1, 1'b0);
      for (int r = 0; r < 3; r++) begin
         sg = rand72();
         gd = ($urandom_range(0, 1) != 0) ? sg : rand72();
         run_session($sformatf("sweep rnd%0d", r), 1'b1, 3, 4, sg, gd, 1'b1, 1'b0);
      end

      // Back-to-back: start held in DONE chains straight into a second session
      sg = rand72();
      run_session("b2b first", 1'b0, 1, 100, sg, sg, 1'b1, 1'b1);
      gd = sg ^ (72'd1 << $urandom_range(0, 71));
      run_session("b2b second", 1'b0, 1, 100, sg, gd, 1'b1, 1'b0);

      // Reset mid-session, during test cycle 50
      set_sigs(1'b0, 72'h5A, 72'h5A);
      set_start(1'b0, 1'b1);
      @(posedge clk); #1;
      set_start(1'b0, 1'b0);
      repeat (99) @(posedge clk);
      #3;
      chk("pre-reset busy a", 72'(bus_a.busy), 72'd1);
      masterRst_n = 1'b0;
      #1;
      chk("async reset outputs a", 72'(obs_a), 72'd0);
      chk("async reset state a", 72'(bus_a.state_dbg), 72'(ST_IDLE));
      chk("async reset outputs b", 72'(obs_b), 72'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("reset hold outputs a", 72'(obs_a), 72'd0);
      masterRst_n = 1'b1;
      @(posedge clk); #1;
      chk("post-reset idle a", 72'(obs_a), 72'd0);
      run_session("after reset", 1'b0, 1, 100, 72'h5A, 72'h5A, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
